pwm_capture: RTL and testbench

Measures an incoming PWM waveform: the high time and the period, in `clk` cycles. Each completed period produces a one-cycle `valid` strobe carrying both counts. It is the receive-side counterpart of the team's 8-bit counter-based PWM generator, and is used for loopback checking and for decoding external PWM inputs. Inputs with no edges (0 % or 100 % duty) are reported through a timeout and a stuck-level flag.

---
 rtl/pwm_capture.sv | 204 ++++++++++++++++++++
 tb/tb_pwm_capture.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Brief    : Measures PWM high time and rise-to-rise period in clk cycles,
//            with timeout/stuck reporting for edge-less inputs.
//            Optional glitch filter enabled by defining PWM_CAP_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             en,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             locked,
    output logic             timeout,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] C_SAT = '1;
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    logic r_s1, r_s2, r_s3;
    logic w_lvl, w_rise, w_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int C_FCW = $clog2(FILT_LEN + 1);

    logic [C_FCW-1:0] r_fcnt;
    logic             r_filt;

    // Level only follows s2 after FILT_LEN consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (r_s2 != r_filt) begin
            if (r_fcnt == C_FCW'(FILT_LEN - 1)) begin
                r_filt <= r_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end else begin
            r_fcnt <= '0;
        end
    end

    assign w_lvl = r_filt;
`else
    logic w_unused_filt_len;
    assign w_unused_filt_len = (FILT_LEN > 0);
    assign w_lvl             = r_s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_s3 <= 1'b0;
        else      r_s3 <= w_lvl;
    end

    assign w_rise = w_lvl & ~r_s3;
    assign w_fall = ~w_lvl & r_s3;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_per, r_hi, r_hil;
    logic [CNT_W-1:0] w_per_n, w_hi_n, w_hil_n, w_high_cnt_n, w_period_cnt_n;
    logic             w_valid_n, w_locked_n, w_timeout_n, w_stuck_n;
    logic             w_sat;

    assign w_sat = (r_per == C_SAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_per      <= '0;
            r_hi       <= '0;
            r_hil      <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_per      <= w_per_n;
            r_hi       <= w_hi_n;
            r_hil      <= w_hil_n;
            high_cnt   <= w_high_cnt_n;
            period_cnt <= w_period_cnt_n;
            valid      <= w_valid_n;
            locked     <= w_locked_n;
            timeout    <= w_timeout_n;
            stuck      <= w_stuck_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_per_n        = r_per;
        w_hi_n         = r_hi;
        w_hil_n        = r_hil;
        w_high_cnt_n   = high_cnt;
        w_period_cnt_n = period_cnt;
        w_valid_n      = 1'b0;
        w_timeout_n    = 1'b0;
        w_locked_n     = locked;
        w_stuck_n      = stuck;

        if (!en) begin
            w_state_n  = S_IDLE;
            w_per_n    = '0;
            w_hi_n     = '0;
            w_hil_n    = '0;
            w_locked_n = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_n = S_ARM;
                    w_per_n   = C_ONE;
                    w_hi_n    = '0;
                end
                // In ARM r_per doubles as the saturation counter for static inputs.
                S_ARM: begin
                    if (w_rise) begin
                        w_state_n = S_HIGH;
                        w_per_n   = C_ONE;
                        w_hi_n    = C_ONE;
                    end else if (w_sat) begin
                        w_timeout_n = 1'b1;
                        w_stuck_n   = w_lvl;
                        w_locked_n  = 1'b0;
                        w_per_n     = C_ONE;
                    end else begin
                        w_per_n = r_per + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_sat) begin
                        w_state_n   = S_ARM;
                        w_timeout_n = 1'b1;
                        w_stuck_n   = w_lvl;
                        w_locked_n  = 1'b0;
                        w_per_n     = C_ONE;
                        w_hi_n      = '0;
                    end else begin
                        w_per_n = r_per + 1'b1;
                        w_hi_n  = r_hi + 1'b1;
                        if (w_fall) begin
                            w_hil_n   = r_hi;
                            w_state_n = S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        w_high_cnt_n   = r_hil;
                        w_period_cnt_n = r_per;
                        w_valid_n      = 1'b1;
                        w_locked_n     = 1'b1;
                        w_stuck_n      = 1'b0;
                        w_per_n        = C_ONE;
                        w_hi_n         = C_ONE;
                        w_state_n      = S_HIGH;
                    end else if (w_sat) begin
                        w_state_n   = S_ARM;
                        w_timeout_n = 1'b1;
                        w_stuck_n   = w_lvl;
                        w_locked_n  = 1'b0;
                        w_per_n     = C_ONE;
                        w_hi_n      = '0;
                    end else begin
                        w_per_n = r_per + 1'b1;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Brief    : Self-checking bench for pwm_capture (CNT_W=10) using a
//            waveform-level reference model of high time and period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int CW  = 10;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          pwm_in;
    logic          en;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] period_cnt;
    logic          valid;
    logic          locked;
    logic          timeout;
    logic          stuck;

    int checks   = 0;
    int failures = 0;

    // Reference model state: input-domain timeline of the driven waveform.
    int   m_t      = 0;
    int   m_nrise  = 0;
    int   m_rise_t = 0;
    int   m_fall_t = 0;
    logic m_prev   = 1'b0;
    int   exp_hi[$];
    int   exp_per[$];
    int   last_hi  = 0;
    int   last_per = 0;

    pwm_capture #(
        .CNT_W   (CW),
        .FILT_LEN(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .en        (en),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout),
        .stuck     (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear(input logic lvl);
        m_nrise = 0;
        m_prev  = lvl;
        exp_hi.delete();
        exp_per.delete();
    endtask

    task automatic restart(input logic lvl);
        rst    = 1'b0;
        en     = 1'b1;
        pwm_in = lvl;
        model_clear(lvl);
        last_hi  = 0;
        last_per = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One input cycle: score the outputs, drive the next level, advance the model.
    task automatic step(input logic v, input bit glitch = 1'b0);
        logic lvl;
        int   eh, ep;
        @(negedge clk);
        if (valid === 1'b1) begin
            checks++;
            if (exp_hi.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid t=%0d high_cnt=%0d period_cnt=%0d required=no strobe",
                         m_t, high_cnt, period_cnt);
            end else begin
                eh = exp_hi.pop_front();
                ep = exp_per.pop_front();
                if (high_cnt !== eh[CW-1:0] || period_cnt !== ep[CW-1:0]) begin
                    failures++;
                    $display("FAIL measurement t=%0d got high=%0d period=%0d required high=%0d period=%0d",
                             m_t, high_cnt, period_cnt, eh, ep);
                end
                checks++;
                if (locked !== 1'b1 || stuck !== 1'b0) begin
                    failures++;
                    $display("FAIL flags_on_valid t=%0d got locked=%b stuck=%b required locked=1 stuck=0",
                             m_t, locked, stuck);
                end
                last_hi  = eh;
                last_per = ep;
            end
        end else begin
            checks++;
            if (valid !== 1'b0 || high_cnt !== last_hi[CW-1:0] || period_cnt !== last_per[CW-1:0]) begin
                failures++;
                $display("FAIL hold t=%0d got valid=%b high=%0d period=%0d required valid=0 high=%0d period=%0d",
                         m_t, valid, high_cnt, period_cnt, last_hi, last_per);
            end
        end
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL spurious_timeout t=%0d got %b required 0", m_t, timeout);
        end
        pwm_in = v;
        lvl    = glitch ? m_prev : v;
        m_t++;
        if (en) begin
            if (lvl && !m_prev) begin
                if (m_nrise > 0) begin
                    exp_hi.push_back(m_fall_t - m_rise_t);
                    exp_per.push_back(m_t - m_rise_t);
                end
                m_rise_t = m_t;
                m_nrise++;
            end
            if (!lvl && m_prev) m_fall_t = m_t;
        end
        m_prev = lvl;
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12; i++) step(1'b0);
        checks++;
        if (exp_hi.size() != 0) begin
            failures++;
            $display("FAIL %s_missed_strobes got pending=%0d required 0", name, exp_hi.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; pwm_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({high_cnt, period_cnt, valid, locked, timeout, stuck} !== '0) begin
            failures++;
            $display("FAIL reset_values got high=%0d period=%0d v=%b l=%b t=%b s=%b required all 0",
                     high_cnt, period_cnt, valid, locked, timeout, stuck);
        end
    endtask

    task automatic test_generator();
        restart(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0);
        for (int i = 0; i < 4; i++) pulse(64, 192);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL gen_locked got %b required 1", locked);
        end
        for (int i = 0; i < 4; i++) pulse(200, 56);
        drain("generator");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) pulse($urandom_range(20, 3), $urandom_range(20, 3));
        drain("random");
    endtask

`ifndef PWM_CAP_FILTER_EN
    task automatic test_min_pulse();
        for (int i = 0; i < 6; i++) pulse(1, 9);
        for (int i = 0; i < 6; i++) pulse(1, 1);
        drain("min_pulse");
    endtask
`else
    task automatic test_filter();
        for (int i = 0; i < 5; i++) begin
            pulse(3, 6);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
            for (int j = 0; j < 9; j++) step(1'b0);
        end
        for (int i = 0; i < 4; i++) pulse(3, 17);
        drain("filter");
    endtask
`endif

    task automatic test_en_abort();
        restart(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0);
        for (int i = 0; i < 3; i++) pulse(40, 30);
        for (int i = 0; i < 10; i++) step(1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1);
        checks++;
        if (locked !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL en_abort_flags got locked=%b valid=%b required 0 0", locked, valid);
        end
        for (int i = 0; i < 5; i++) step(1'b0);
        en = 1'b1;
        model_clear(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0);
        for (int i = 0; i < 3; i++) pulse(25, 15);
        drain("en_abort");
    endtask

    task automatic test_rst_abort();
        for (int i = 0; i < 3; i++) pulse(30, 20);
        for (int i = 0; i < 8; i++) step(1'b1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({high_cnt, period_cnt, valid, locked, timeout, stuck} !== '0) begin
            failures++;
            $display("FAIL rst_abort got high=%0d period=%0d v=%b l=%b t=%b s=%b required all 0",
                     high_cnt, period_cnt, valid, locked, timeout, stuck);
        end
        model_clear(1'b0);
        last_hi  = 0;
        last_per = 0;
        pwm_in   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0);
        for (int i = 0; i < 3; i++) pulse(12, 21);
        drain("rst_abort");
    endtask

    task automatic test_timeout(input logic lvl);
        int t, last, seen;
        restart(lvl);
        t = 0; last = 0; seen = 0;
        while (seen < 3 && t < 3300) begin
            @(negedge clk);
            t++;
            if (timeout === 1'b1) begin
                checks++;
                if (seen == 0 && lvl == 1'b0 && (t < SAT || t > SAT + 2)) begin
                    failures++;
                    $display("FAIL timeout_first got cycle=%0d required %0d..%0d", t, SAT, SAT + 2);
                end else if (seen > 0 && t - last != SAT) begin
                    failures++;
                    $display("FAIL timeout_interval got %0d required %0d", t - last, SAT);
                end
                checks++;
                if (stuck !== lvl || locked !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_flags got stuck=%b locked=%b required stuck=%b locked=0",
                             stuck, locked, lvl);
                end
                last = t;
                seen++;
            end
        end
        checks++;
        if (seen < 3) begin
            failures++;
            $display("FAIL timeout_missing got %0d strobes required 3", seen);
        end
    endtask

    task automatic test_stuck_clear();
        for (int i = 0; i < 5; i++) step(1'b0);
        checks++;
        if (stuck !== 1'b1) begin
            failures++;
            $display("FAIL stuck_before_valid got %b required 1", stuck);
        end
        for (int i = 0; i < 3; i++) pulse(5, 5);
        drain("stuck_clear");
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; pwm_in = 1'b0;
        test_reset();
        test_generator();
        test_random();
`ifndef PWM_CAP_FILTER_EN
        test_min_pulse();
`else
        test_filter();
`endif
        test_en_abort();
        test_rst_abort();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_stuck_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
